// File: rtl/config_read_arbiter.sv
// Round-robin arbiter sharing one config-register read port among N_REQ requesters.
// One read in flight at a time; a silent slave is answered with an error response after a timeout.
module config_read_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int AXI_ADDR_BITS  = 32,
    parameter int AXIL_DATA_BITS = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_REQ*AXI_ADDR_BITS-1:0]   req_read_addr,
    input  logic [N_REQ-1:0]                 req_read_valid,
    output logic [N_REQ-1:0]                 req_read_ready,
    output logic [AXIL_DATA_BITS-1:0]        req_resp_data,
    output logic                             req_resp_error,
    output logic [N_REQ-1:0]                 req_resp_valid,
    input  logic [N_REQ-1:0]                 req_resp_ready,
    output logic [AXI_ADDR_BITS-1:0]         cfg_read_addr,
    output logic                             cfg_read_valid,
    input  logic                             cfg_read_ready,
    input  logic [AXIL_DATA_BITS-1:0]        cfg_resp_data,
    input  logic                             cfg_resp_error,
    input  logic                             cfg_resp_valid,
    output logic                             cfg_resp_ready,
    output logic                             busy,
    output logic [15:0]                      timeout_count
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] LAST_REQ  = GW'(N_REQ - 1);
    localparam logic [GW:0]   N_WIDE    = (GW+1)'(N_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        ERR_RESP  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [GW-1:0]           grant_q;
    logic [GW-1:0]           rr_ptr_q;
    logic [TW-1:0]           tmo_q;
    logic [15:0]             timeout_count_q;
    logic [AXI_ADDR_BITS-1:0] addr_q;

    logic [AXI_ADDR_BITS-1:0] addr_slice [N_REQ];
    logic [GW-1:0]           pick;
    logic [GW:0]             scan_idx;
    logic [GW-1:0]           next_ptr;
    logic [TW-1:0]           tmo_inc;
    logic                    tmo_hit;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
        assign addr_slice[gi] = req_read_addr[gi*AXI_ADDR_BITS +: AXI_ADDR_BITS];
    end

    // Scan downward in offset so the requester closest above rr_ptr is the last (winning) write.
    always_comb begin
        pick     = rr_ptr_q;
        scan_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr_q} + (GW+1)'(k);
            if (scan_idx >= N_WIDE) begin
                scan_idx = scan_idx - N_WIDE;
            end
            if (req_read_valid[scan_idx[GW-1:0]]) begin
                pick = scan_idx[GW-1:0];
            end
        end
    end

    assign next_ptr = (grant_q == LAST_REQ) ? '0 : grant_q + GW'(1);
    assign tmo_inc  = tmo_q + TW'(1);
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_inc == TMO_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            rr_ptr_q        <= '0;
            tmo_q           <= '0;
            timeout_count_q <= '0;
            addr_q          <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_read_valid) begin
                        grant_q <= pick;
                        addr_q  <= addr_slice[pick];
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cfg_read_ready) begin
                        tmo_q   <= '0;
                        state_q <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    // A real response in the timeout cycle takes priority over the error path.
                    if (cfg_resp_valid && req_resp_ready[grant_q]) begin
                        rr_ptr_q <= next_ptr;
                        addr_q   <= '0;
                        state_q  <= IDLE;
                    end else if (!cfg_resp_valid) begin
                        tmo_q <= tmo_inc;
                        if (tmo_hit) begin
                            state_q <= ERR_RESP;
                            if (timeout_count_q != 16'hFFFF) begin
                                timeout_count_q <= timeout_count_q + 16'd1;
                            end
                        end
                    end
                end
                ERR_RESP: begin
                    if (req_resp_ready[grant_q]) begin
                        rr_ptr_q <= next_ptr;
                        addr_q   <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_read_ready = '0;
        req_resp_valid = '0;
        req_resp_data  = '0;
        req_resp_error = 1'b0;
        cfg_resp_ready = 1'b1;
        case (state_q)
            ISSUE: begin
                req_read_ready[grant_q] = cfg_read_ready;
            end
            WAIT_RESP: begin
                req_resp_valid[grant_q] = cfg_resp_valid;
                req_resp_data           = cfg_resp_data;
                req_resp_error          = cfg_resp_error;
                cfg_resp_ready          = req_resp_ready[grant_q];
            end
            ERR_RESP: begin
                req_resp_valid[grant_q] = 1'b1;
                req_resp_error          = 1'b1;
            end
            default: ;
        endcase
    end

    assign cfg_read_addr  = addr_q;
    assign cfg_read_valid = (state_q == ISSUE);
    assign busy           = (state_q != IDLE);
    assign timeout_count  = timeout_count_q;

endmodule

// File: tb/tb_config_read_arbiter.sv
// Scoreboard bench for config_read_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares on every requester response handshake.
module tb_config_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N*AW-1:0] req_read_addr;
    logic [N-1:0]    req_read_valid;
    logic [N-1:0]    req_read_ready;
    logic [DW-1:0]   req_resp_data;
    logic            req_resp_error;
    logic [N-1:0]    req_resp_valid;
    logic [N-1:0]    req_resp_ready;
    logic [AW-1:0]   cfg_read_addr;
    logic            cfg_read_valid;
    logic            cfg_read_ready;
    logic [DW-1:0]   cfg_resp_data;
    logic            cfg_resp_error;
    logic            cfg_resp_valid;
    logic            cfg_resp_ready;
    logic            busy;
    logic [15:0]     timeout_count;

    config_read_arbiter #(
        .N_REQ(N), .TIMEOUT_CYCLES(8), .AXI_ADDR_BITS(AW), .AXIL_DATA_BITS(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_read_addr(req_read_addr), .req_read_valid(req_read_valid),
        .req_read_ready(req_read_ready), .req_resp_data(req_resp_data),
        .req_resp_error(req_resp_error), .req_resp_valid(req_resp_valid),
        .req_resp_ready(req_resp_ready), .cfg_read_addr(cfg_read_addr),
        .cfg_read_valid(cfg_read_valid), .cfg_read_ready(cfg_read_ready),
        .cfg_resp_data(cfg_resp_data), .cfg_resp_error(cfg_resp_error),
        .cfg_resp_valid(cfg_resp_valid), .cfg_resp_ready(cfg_resp_ready),
        .busy(busy), .timeout_count(timeout_count)
    );

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests_run = 0;
    int   tests_failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("[TB] ok   %s = %0h (t=%0t)", name, act, $time);
        end
    endtask

    task automatic push_exp(input int idx, input logic [31:0] data, input logic err);
        exp_t e;
        e.idx  = 2'(idx);
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    // Monitor: every requester response handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_resp_valid != '0) begin
                chk("resp_valid_onehot", 64'($countones(req_resp_valid)), 64'd1);
            end
            for (int i = 0; i < N; i++) begin
                if (req_resp_valid[i] && req_resp_ready[i]) begin
                    if (sb.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL unexpected_resp: requester %0d got data %0h, expected none", i, req_resp_data);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("resp_requester", 64'(i), 64'(mon_e.idx));
                        chk("resp_data", 64'(req_resp_data), 64'(mon_e.data));
                        chk("resp_error", 64'(req_resp_error), 64'(mon_e.err));
                    end
                end
            end
        end
    end

    // Waits for ISSUE, checks grant and address, then completes a zero-wait read.
    task automatic serve(input int req, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] clr);
        bit seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cfg_read_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("serve_issue_timeout", 64'd0, 64'd1);
            return;
        end
        chk("grant_ready", 64'(req_read_ready), 64'(4'b0001 << req));
        chk("cfg_read_addr", 64'(cfg_read_addr), 64'(addr));
        push_exp(req, data, 1'b0);
        @(posedge clk); #1;
        req_read_valid = req_read_valid & ~clr;
        cfg_resp_valid = 1'b1;
        cfg_resp_data  = data;
        @(posedge clk); #1;
        cfg_resp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        req_read_addr  = {32'h0000_003C, 32'h0000_0040, 32'h0000_0024, 32'h0000_0010};
        req_read_valid = '0;
        req_resp_ready = 4'hF;
        cfg_read_ready = 1'b1;
        cfg_resp_data  = '0;
        cfg_resp_error = 1'b0;
        cfg_resp_valid = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cfg_read_valid", 64'(cfg_read_valid), 64'd0);
        chk("rst_cfg_read_addr", 64'(cfg_read_addr), 64'd0);
        chk("rst_req_read_ready", 64'(req_read_ready), 64'd0);
        chk("rst_req_resp_valid", 64'(req_resp_valid), 64'd0);
        chk("rst_cfg_resp_ready", 64'(cfg_resp_ready), 64'd1);
        chk("rst_timeout_count", 64'(timeout_count), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Round-robin: all requesters hold valid, expected order 0,1,2,3,0
        req_read_valid = 4'hF;
        serve(0, 32'h10, 32'hA000_0000, 4'h0);
        serve(1, 32'h24, 32'hA000_0001, 4'h0);
        serve(2, 32'h40, 32'hA000_0002, 4'h0);
        serve(3, 32'h3C, 32'hA000_0003, 4'h0);
        serve(0, 32'h10, 32'hA000_0010, 4'hF);

        // Single read from requester 2
        req_read_valid = 4'b0100;
        serve(2, 32'h40, 32'hDEAD_BEEF, 4'b0100);
        @(negedge clk);
        chk("single_busy_done", 64'(busy), 64'd0);

        // Backpressure on both the request and response side
        @(posedge clk); #1;
        cfg_read_ready = 1'b0;
        req_read_valid = 4'b0010;
        @(posedge clk); #1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("bp_cfg_valid", 64'(cfg_read_valid), 64'd1);
            chk("bp_cfg_addr", 64'(cfg_read_addr), 64'h24);
            chk("bp_req_ready", 64'(req_read_ready), 64'd0);
            @(posedge clk); #1;
        end
        cfg_read_ready = 1'b1;
        @(negedge clk);
        chk("bp_req_ready_pass", 64'(req_read_ready), 64'b0010);
        @(posedge clk); #1;
        req_read_valid = '0;
        req_resp_ready = 4'b1101;
        cfg_resp_valid = 1'b1;
        cfg_resp_data  = 32'hCAFE_0001;
        push_exp(1, 32'hCAFE_0001, 1'b0);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("bp_resp_held", 64'(req_resp_valid), 64'b0010);
            chk("bp_cfg_resp_ready", 64'(cfg_resp_ready), 64'd0);
            @(posedge clk); #1;
        end
        req_resp_ready = 4'hF;
        @(posedge clk); #1;
        cfg_resp_valid = 1'b0;
        @(negedge clk);
        chk("bp_busy_done", 64'(busy), 64'd0);

        // Timeout: requester 0, slave never responds
        @(posedge clk); #1;
        req_read_valid = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        chk("tmo_cfg_addr", 64'(cfg_read_addr), 64'h10);
        push_exp(0, 32'h0, 1'b1);
        @(posedge clk); #1;
        req_read_valid = '0;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            chk("tmo_wait_quiet", 64'(req_resp_valid), 64'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("tmo_err_valid", 64'(req_resp_valid), 64'b0001);
        chk("tmo_err_error", 64'(req_resp_error), 64'd1);
        chk("tmo_err_data", 64'(req_resp_data), 64'd0);
        chk("tmo_count", 64'(timeout_count), 64'd1);
        @(posedge clk); #1;
        cfg_resp_valid = 1'b1;
        cfg_resp_data  = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("late_cfg_resp_ready", 64'(cfg_resp_ready), 64'd1);
        chk("late_not_forwarded", 64'(req_resp_valid), 64'd0);
        @(posedge clk); #1;
        cfg_resp_valid = 1'b0;

        // Race: response arrives in the cycle the counter would hit the limit
        req_read_valid = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        chk("race_cfg_addr", 64'(cfg_read_addr), 64'h3C);
        push_exp(3, 32'h1234_5678, 1'b0);
        @(posedge clk); #1;
        req_read_valid = '0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        cfg_resp_valid = 1'b1;
        cfg_resp_data  = 32'h1234_5678;
        @(posedge clk); #1;
        cfg_resp_valid = 1'b0;
        @(negedge clk);
        chk("race_busy_done", 64'(busy), 64'd0);
        chk("race_tmo_count", 64'(timeout_count), 64'd1);

        // Reset in the middle of WAIT_RESP, then requester 3 is served
        @(posedge clk); #1;
        req_read_valid = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        chk("mid_grant", 64'(req_read_ready), 64'b0010);
        @(posedge clk); #1;
        req_read_valid = '0;
        req_resp_ready = 4'b0000;
        @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_cfg_resp_ready", 64'(cfg_resp_ready), 64'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_cfg_read_addr", 64'(cfg_read_addr), 64'd0);
        chk("arst_cfg_resp_ready", 64'(cfg_resp_ready), 64'd1);
        chk("arst_timeout_count", 64'(timeout_count), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_resp_ready = 4'hF;
        req_read_valid = 4'b1000;
        serve(3, 32'h3C, 32'h3333_0003, 4'b1000);
        @(negedge clk);
        chk("post_rst_busy_done", 64'(busy), 64'd0);

        @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/config_read_arbiter.md
Name: config_read_arbiter

Overview:
- Round-robin arbiter that lets N_REQ requesters share one config-register read port.
- Each requester port is a read_config-style master: a read request channel plus a response channel. The shared port is a read_config-style slave.
- One read is in flight at a time. The response goes back to the requester that issued the read.
- A response timeout returns an error, so a silent register file cannot block requesters.
- Sits between kernel-side config readers and the config register block.

Parameters:
- N_REQ, 4, number of requesters; minimum 2.
- TIMEOUT_CYCLES, 1024, cycles to wait in WAIT_RESP before sending an error response; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_read_addr  in  N_REQ*AXI_ADDR_BITS  per-requester read address; requester i uses slice i
- req_read_valid  in  N_REQ  per-requester request valid
- req_read_ready  out  N_REQ  per-requester request ready
- req_resp_data  out  AXIL_DATA_BITS  response data, shared by all requesters, qualified by req_resp_valid
- req_resp_error  out  1  response error, shared, qualified by req_resp_valid
- req_resp_valid  out  N_REQ  per-requester response valid, one-hot or zero
- req_resp_ready  in  N_REQ  per-requester response ready
- cfg_read_addr  out  AXI_ADDR_BITS  shared-port read address
- cfg_read_valid  out  1  shared-port request valid
- cfg_read_ready  in  1  shared-port request ready
- cfg_resp_data  in  AXIL_DATA_BITS  shared-port response data
- cfg_resp_error  in  1  shared-port response error
- cfg_resp_valid  in  1  shared-port response valid
- cfg_resp_ready  out  1  shared-port response ready
- busy  out  1  high when the state is not IDLE
- timeout_count  out  16  number of timeouts; saturates at 0xFFFF

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state: state=IDLE, grant=0, rr_ptr=0, timeout counter=0, timeout_count=0.
- Output values in reset / IDLE: cfg_read_addr=0, cfg_read_valid=0, req_read_ready=0, req_resp_valid=0, req_resp_data=0, req_resp_error=0, busy=0, cfg_resp_ready=1.
- Reset mid-operation: the in-flight transaction is abandoned with no response. Requesters must reissue it.
- State IDLE: if any req_read_valid is high, select the first set bit scanning upward from rr_ptr with wrap-around.
  - Register grant=g and cfg_read_addr=req_read_addr[g].
  - Next state ISSUE. Requests take 1 cycle from IDLE to ISSUE.
- State ISSUE:
  - cfg_read_valid=1.
  - req_read_ready[g]=cfg_read_ready (combinational pass-through); all other bits of req_read_ready are 0.
  - When cfg_read_valid and cfg_read_ready are both high, go to WAIT_RESP and clear the timeout counter.
  - cfg_read_addr stays stable throughout ISSUE.
- State WAIT_RESP:
  - req_resp_valid[g]=cfg_resp_valid.
  - req_resp_data=cfg_resp_data and req_resp_error=cfg_resp_error.
  - cfg_resp_ready=req_resp_ready[g].
  - When cfg_resp_valid and cfg_resp_ready are both high: set rr_ptr=(g+1) mod N_REQ and go to IDLE.
  - The timeout counter increments every cycle in which cfg_resp_valid=0.
  - When the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), go to ERR_RESP and increment timeout_count (saturating).
  - If cfg_resp_valid is high in that same cycle, the real response wins and no timeout is taken.
- State ERR_RESP:
  - req_resp_valid[g]=1, req_resp_data=0, req_resp_error=1.
  - cfg_resp_ready=1, so a late response is discarded.
  - When req_resp_ready[g] is high: set rr_ptr=(g+1) mod N_REQ and go to IDLE.
- Stale responses: in IDLE, ISSUE and ERR_RESP, cfg_resp_ready=1 and any cfg_resp_valid beat is dropped. A stale beat is never forwarded to a requester.
- Response ordering: requester responses are never sent before the matching request handshake completes.
- Fairness: a continuously requesting requester is served within N_REQ grants.
- Stability: the ISSUE and ERR_RESP outputs meet the stable-while-valid-and-not-ready rule. WAIT_RESP outputs are stable as long as the shared slave obeys the same rule.
- Grant timing: a requester that raises valid while another transaction is in flight is only considered at the next IDLE.

Test Plan:
- Single read: requester 2 reads addr 0x40, cfg_read_ready=1, slave responds with data 0xDEADBEEF one cycle later → cfg_read_addr=0x40 in the cycle after the request; req_resp_valid=4'b0100 with data 0xDEADBEEF and error 0; busy returns to 0.
- Round-robin: all 4 requesters hold valid continuously, slave has zero-wait response → grant order 0,1,2,3,0. No requester is granted twice before every other valid requester is granted once.
- Backpressure: cfg_read_ready=0 for 5 cycles, then requester 1 holds req_resp_ready=0 for 3 cycles → cfg_read_addr and cfg_read_valid stay stable for all 5 stall cycles; req_read_ready[1]=0 throughout; the response is delivered exactly once after the stall.
- Timeout with TIMEOUT_CYCLES=8, no slave response → after 8 WAIT_RESP cycles requester 0 sees resp_valid=1, error=1, data=0; timeout_count=1. A late cfg_resp_valid arriving in IDLE is accepted and not forwarded.
- Race: the response arrives in the same cycle the counter reaches TIMEOUT_CYCLES → the real data is forwarded and timeout_count is unchanged.
- Reset mid-transaction: assert rst during WAIT_RESP → all outputs take their reset values asynchronously. After deassertion, a new request from requester 3 is granted normally because rr_ptr=0 and the scan reaches requester 3.
